// File: rtl/dec_reg_bank.sv
// -----------------------------------------------------------------------------
// dec_reg_bank
//   Parametrised register bank with a decoded write path. The write address is
//   turned into a one-hot enable (generalised 3-to-8 decoder), which drives the
//   DATA_W-wide storage flops. Adds per-entry valid bits, a registered read
//   port with same-cycle write-to-read bypass, a bank-wide clear and a
//   registered copy of the decoded write strobe.
//
// Parameters
//   ADDR_W     address width, DEPTH = 2**ADDR_W entries
//   DATA_W     width of each entry
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         global enable, qualifies clr / wr_en / rd_en
//   clr        synchronous clear of all entries (wins over a same-cycle write)
//   wr_en      write request
//   wr_addr    write address
//   wr_data    write data
//   rd_en      read request
//   rd_addr    read address
//   rd_data    registered read data
//   rd_valid   one-cycle pulse marking a new read result
//   rd_hit     addressed entry was valid at read time
//   wr_onehot  registered decoded write strobe, one cycle after a write
//   valid_map  per-entry valid bits
// -----------------------------------------------------------------------------
module dec_reg_bank #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  localparam int DEPTH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_hit,
  output logic [DEPTH-1:0]  wr_onehot,
  output logic [DEPTH-1:0]  valid_map
);

  // Qualified commands
  logic              acc_wr_s;
  logic              acc_rd_s;
  logic              acc_clr_s;
  logic              bypass_s;
  logic [DEPTH-1:0]  wr_dec_s;

  // State and next state
  logic [DATA_W-1:0] mem_q     [DEPTH];
  logic [DATA_W-1:0] mem_d     [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [DEPTH-1:0]  onehot_q;
  logic [DEPTH-1:0]  onehot_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;
  logic              rd_valid_q;
  logic              rd_valid_d;
  logic              rd_hit_q;
  logic              rd_hit_d;

  // Command qualification: clear always beats a write in the same cycle.
  assign acc_clr_s = en & clr;
  assign acc_wr_s  = en & wr_en & ~clr;
  assign acc_rd_s  = en & rd_en;
  assign bypass_s  = acc_wr_s & (wr_addr == rd_addr);

  // Address decoder: one-hot enable, one output per entry.
  always_comb begin
    wr_dec_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr == ADDR_W'(i)) begin
        wr_dec_s[i] = 1'b1;
      end else begin
        wr_dec_s[i] = 1'b0;
      end
    end
  end

  // Next-state logic for storage, valid bits and the write strobe.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    onehot_d = '0;
    if (acc_clr_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      valid_d = '0;
    end else if (acc_wr_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_dec_s[i]) begin
          mem_d[i] = wr_data;
        end else begin
          mem_d[i] = mem_q[i];
        end
      end
      valid_d  = valid_q | wr_dec_s;
      onehot_d = wr_dec_s;
    end else begin
      onehot_d = '0;
    end
  end

  // Read port next state; storage is sampled before this edge's update, so a
  // same-address write is forwarded directly from the write bus.
  always_comb begin
    rd_valid_d = acc_rd_s;
    rd_data_d  = rd_data_q;
    rd_hit_d   = rd_hit_q;
    if (acc_rd_s) begin
      if (acc_clr_s) begin
        rd_data_d = '0;
        rd_hit_d  = 1'b0;
      end else if (bypass_s) begin
        rd_data_d = wr_data;
        rd_hit_d  = 1'b1;
      end else begin
        rd_data_d = mem_q[rd_addr];
        rd_hit_d  = valid_q[rd_addr];
      end
    end else begin
      rd_data_d = rd_data_q;
      rd_hit_d  = rd_hit_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q    <= '0;
      onehot_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      valid_q    <= valid_d;
      onehot_q   <= onehot_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_hit_q   <= rd_hit_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_hit    = rd_hit_q;
  assign wr_onehot = onehot_q;
  assign valid_map = valid_q;

endmodule

// File: tb/tb_dec_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_dec_reg_bank
//   Drives two dec_reg_bank instances (8x8 and 16x16) from one shared command
//   stream; the 8x8 instance sees the low address/data bits. A behavioural
//   model (plain arrays) predicts each instance; read results go through a
//   queue scoreboard consumed by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_dec_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clr, wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;

  logic [7:0]  rd_data_a, wr_onehot_a, valid_map_a;
  logic        rd_valid_a, rd_hit_a;
  logic [15:0] rd_data_b, wr_onehot_b, valid_map_b;
  logic        rd_valid_b, rd_hit_b;

  always #5 clk = ~clk;

  dec_reg_bank #(.ADDR_W(3), .DATA_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data[7:0]),
    .rd_en(rd_en), .rd_addr(rd_addr[2:0]),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_hit(rd_hit_a),
    .wr_onehot(wr_onehot_a), .valid_map(valid_map_a)
  );

  dec_reg_bank #(.ADDR_W(4), .DATA_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_hit(rd_hit_b),
    .wr_onehot(wr_onehot_b), .valid_map(valid_map_b)
  );

  typedef struct {
    int          edge_no;
    logic [15:0] data;
    logic        hit;
  } rd_exp_t;

  rd_exp_t     q0[$];
  rd_exp_t     q1[$];
  logic [15:0] mem_m [2][16];
  logic [15:0] vmap_m[2];
  logic [15:0] oh_m[2];
  logic [15:0] last_d[2];
  logic        last_h[2];
  int          edge_no = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 16; j++) mem_m[k][j] = 16'h0;
      vmap_m[k] = 16'h0;
      oh_m[k]   = 16'h0;
      last_d[k] = 16'h0;
      last_h[k] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Apply the rules for one clock edge to both model instances.
  task automatic model_edge(input logic e, input logic c, input logic w, input logic [3:0] wa,
                            input logic [15:0] wd, input logic r, input logic [3:0] ra);
    logic        acc_wr, acc_rd, acc_clr;
    int          wak, rak;
    logic [15:0] wdk;
    rd_exp_t     ent;
    acc_clr = e & c;
    acc_wr  = e & w & ~c;
    acc_rd  = e & r;
    for (int k = 0; k < 2; k++) begin
      wak = (k == 0) ? int'(wa[2:0]) : int'(wa);
      rak = (k == 0) ? int'(ra[2:0]) : int'(ra);
      wdk = (k == 0) ? (wd & 16'h00FF) : wd;
      if (acc_rd) begin
        ent.edge_no = edge_no;
        if (acc_clr) begin
          ent.data = 16'h0; ent.hit = 1'b0;
        end else if (acc_wr && wak == rak) begin
          ent.data = wdk; ent.hit = 1'b1;
        end else begin
          ent.data = mem_m[k][rak]; ent.hit = vmap_m[k][rak];
        end
        last_d[k] = ent.data;
        last_h[k] = ent.hit;
        if (k == 0) q0.push_back(ent);
        else        q1.push_back(ent);
      end
      if (acc_clr) begin
        for (int j = 0; j < 16; j++) mem_m[k][j] = 16'h0;
        vmap_m[k] = 16'h0;
      end else if (acc_wr) begin
        mem_m[k][wak]  = wdk;
        vmap_m[k][wak] = 1'b1;
      end
      oh_m[k] = acc_wr ? (16'h1 << wak) : 16'h0;
    end
  endtask

  // One clock cycle of stimulus; returns 1 time unit after the rising edge.
  task automatic cyc(input logic e, input logic c, input logic w, input logic [3:0] wa,
                     input logic [15:0] wd, input logic r, input logic [3:0] ra);
    en = e; clr = c; wr_en = w; wr_addr = wa; wr_data = wd; rd_en = r; rd_addr = ra;
    @(posedge clk);
    edge_no++;
    if (rst_n) model_edge(e, c, w, wa, wd, r, ra);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
  endtask

  // Reset dropped between edges: outputs must clear without a clock edge,
  // and a pending read result is discarded.
  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rd_valid_a", rd_valid_a, 1'b0);
    chk("rst_rd_data_a", rd_data_a, 8'h00);
    chk("rst_valid_map_a", valid_map_a, 8'h00);
    chk("rst_onehot_a", wr_onehot_a, 8'h00);
    chk("rst_rd_hit_b", rd_hit_b, 1'b0);
    chk("rst_valid_map_b", valid_map_b, 16'h0000);
    chk("rst_rd_data_b", rd_data_b, 16'h0000);
    cyc(1'b1, 1'b0, 1'b1, 4'h4, 16'h4444, 1'b1, 4'h4);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every cycle, popping the scoreboard on rd_valid.
  always @(negedge clk) begin
    rd_exp_t e;
    chk("a_rd_valid", rd_valid_a, q0.size() != 0);
    if (q0.size() != 0) begin
      e = q0.pop_front();
      chk("a_rd_latency", edge_no, e.edge_no);
      chk("a_rd_data", rd_data_a, e.data);
      chk("a_rd_hit", rd_hit_a, e.hit);
    end else begin
      chk("a_rd_data_hold", rd_data_a, last_d[0]);
      chk("a_rd_hit_hold", rd_hit_a, last_h[0]);
    end
    chk("a_wr_onehot", wr_onehot_a, oh_m[0]);
    chk("a_valid_map", valid_map_a, vmap_m[0]);
    chk("b_rd_valid", rd_valid_b, q1.size() != 0);
    if (q1.size() != 0) begin
      e = q1.pop_front();
      chk("b_rd_latency", edge_no, e.edge_no);
      chk("b_rd_data", rd_data_b, e.data);
      chk("b_rd_hit", rd_hit_b, e.hit);
    end else begin
      chk("b_rd_data_hold", rd_data_b, last_d[1]);
      chk("b_rd_hit_hold", rd_hit_b, last_h[1]);
    end
    chk("b_wr_onehot", wr_onehot_b, oh_m[1]);
    chk("b_valid_map", valid_map_b, vmap_m[1]);
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = 4'h0; rd_addr = 4'h0; wr_data = 16'h0;
    model_reset();
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
    rst_n = 1'b1;

    // Read after reset
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 4'h5);
    chk("post_rst_read_a", {rd_valid_a, rd_hit_a, rd_data_a}, {1'b1, 1'b0, 8'h00});
    idle();

    // Write then read back
    cyc(1'b1, 1'b0, 1'b1, 4'h3, 16'h12A5, 1'b0, 4'h0);
    chk("wr3_onehot_a", wr_onehot_a, 8'h08);
    chk("wr3_vmap_b", valid_map_b, 16'h0008);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 4'h3);
    chk("rd3_data_a", rd_data_a, 8'hA5);

    // Bypass and non-matching same-cycle write
    cyc(1'b1, 1'b0, 1'b1, 4'h6, 16'h3C3C, 1'b1, 4'h6);
    chk("bypass_a", {rd_hit_a, rd_data_a}, {1'b1, 8'h3C});
    cyc(1'b1, 1'b0, 1'b1, 4'h1, 16'h0111, 1'b1, 4'h6);
    chk("nobypass_a", rd_data_a, 8'h3C);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 4'h1);
    chk("rd1_data_b", rd_data_b, 16'h0111);

    // Fill then clear with a colliding write and read
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 1'b0, 1'b1, 4'(i), {8'(i), 8'h10 + 8'(i % 8)}, 1'b1, 4'(15 - i));
    cyc(1'b1, 1'b1, 1'b1, 4'h2, 16'hFFFF, 1'b1, 4'h4);
    chk("clr_out_a", {rd_hit_a, rd_data_a, valid_map_a, wr_onehot_a}, 25'h0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 4'h2);
    idle();

    // Global enable low
    cyc(1'b1, 1'b0, 1'b1, 4'h5, 16'h5A5A, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 1'b1, 4'h5, 16'hDEAD, 1'b1, 4'h5);
    cyc(1'b0, 1'b0, 1'b1, 4'h9, 16'hBEEF, 1'b1, 4'h9);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 4'h5);
    chk("en0_keep_b", rd_data_b, 16'h5A5A);

    // Top address on the wide instance
    cyc(1'b1, 1'b0, 1'b1, 4'hF, 16'hBEEF, 1'b0, 4'h0);
    chk("wr15_onehot_b", wr_onehot_b, 16'h8000);
    chk("wr15_onehot_a", wr_onehot_a, 8'h80);

    // Asynchronous reset with a read in flight
    cyc(1'b1, 1'b0, 1'b1, 4'h7, 16'h7777, 1'b1, 4'hF);
    async_reset();
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 4'hF);
    chk("post_ar_b", {rd_valid_b, rd_hit_b, rd_data_b}, {1'b1, 1'b0, 16'h0});
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 4'h7);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 4'h5);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) async_reset();
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0, 1'($urandom),
          4'($urandom), 16'($urandom), 1'($urandom),
          ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom));
    end
    idle();
    idle();
    chk("sb_drained", q0.size() + q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
